skin_det_frame_ctrl: RTL and testbench
======================================

Name: skin_det_frame_ctrl

Overview:
- Frame-level controller for the YCbCr skin-mask pipeline in the HumanDetector path.
- Owns the Cb/Cr threshold registers. Host writes go to a shadow set, which is committed to the datapath only at frame boundaries.
- Sequences per-frame accumulation of the 1-bit skin mask: pixel count and bounding box.
- Publishes one result record per complete frame to the overlay/stitching logic.

Parameters:
- H_W, 11, width of the column counter and the x box outputs.
- V_W, 11, width of the row counter and the y box outputs.
- CNT_W, 21, width of the skin-pixel counter (saturating).
- MIN_PIX, 256, minimum skin count for det_found=1.
- CB_LO_INIT / CB_HI_INIT / CR_LO_INIT / CR_HI_INIT, 77 / 130 / 137 / 162, threshold reset values.

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst  in  1  reset: synchronous, active-high.
- det_en  in  1  detection enable. Sampled only at a frame start.
- cfg_we  in  1  shadow threshold write strobe.
- cfg_addr  in  2  register select: 0=cb_lo, 1=cb_hi, 2=cr_lo, 3=cr_hi.
- cfg_wdata  in  8  shadow write data.
- in_vsync  in  1  vsync, aligned with in_mask. Active-high; the rising edge marks frame start.
- in_href  in  1  line valid, aligned with in_mask.
- in_de  in  1  pixel valid, aligned with in_mask.
- in_mask  in  1  skin-mask bit, 1 = skin pixel.
- thr_cb_lo / thr_cb_hi / thr_cr_lo / thr_cr_hi  out  8 each  active thresholds driven to the datapath compare (exclusive bounds).
- res_valid  out  1  one-cycle pulse; result record updated.
- det_found  out  1  skin_cnt >= MIN_PIX for the last frame.
- skin_cnt  out  CNT_W  skin pixel count of the last frame.
- box_xmin / box_xmax  out  H_W each  bounding-box column limits.
- box_ymin / box_ymax  out  V_W each  bounding-box row limits.
- busy  out  1  high while in ACTIVE.

Behaviour:
- Reset:
  - Active thresholds and shadow thresholds = *_INIT; pending flag = 0.
  - res_valid=0, det_found=0, skin_cnt=0, all box outputs=0, busy=0.
  - FSM = IDLE; vsync/href edge registers = 0.
  - Reset asserted mid-frame discards the partial accumulation; no res_valid is produced for that frame.
- Edge detection: vs_rise = in_vsync & ~vs_d; hr_fall = ~in_href & hr_d (1-cycle registered history).
- Shadow writes: cfg_we writes shadow[cfg_addr] and sets pending=1. Multiple writes within one frame all commit together.
- Commit: on any vs_rise with pending=1:
  - active <= shadow; pending <= 0.
  - A cfg_we in the same cycle as vs_rise updates the shadow and leaves pending=1; it commits at the next vs_rise.
- FSM states:
  - IDLE: on vs_rise & det_en -> ACTIVE; clear accumulators.
  - ACTIVE, on vs_rise: -> LATCH.
  - ACTIVE, on det_en=0 without vs_rise: stay ACTIVE. det_en is re-sampled at the next vs_rise.
  - LATCH: one cycle. Register results, pulse res_valid, clear accumulators. Then -> ACTIVE if det_en, else -> IDLE.
  - The commit happens on the vs_rise cycle itself, so the new frame always uses the new thresholds.
- Counters, ACTIVE only:
  - x increments on in_de and resets to 0 on hr_fall.
  - y increments on hr_fall only if the line contained ≥1 de; y resets at frame start.
  - x and y saturate at all-ones.
- Accumulate: when in_de & in_mask:
  - skin_cnt_acc += 1, saturating at 2^CNT_W-1.
  - xmin=min, xmax=max, ymin=min, ymax=max against the current (x, y).
  - Accumulator init: min = all-ones, max = 0.
- Latched result, frame with zero skin pixels: box outputs = 0, skin_cnt = 0, det_found = 0.
- Output timing: result outputs change only in the LATCH cycle. res_valid is high exactly in the cycle after LATCH entry, i.e. 2 clk after the vs_rise input. Results hold until the next LATCH.
- vs_rise while IDLE with det_en=0: thresholds still commit; no result is produced.
- The first frame after enable produces no result until its closing vs_rise.
- in_de outside in_href is still counted. The datapath guarantees de⊆href.

Decomposition:
- Shared package skin_det_pkg:
  - FSM state enum {IDLE, ACTIVE, LATCH}.
  - Register address constants.
  - Default threshold constants, shared with the YCbCr datapath.
- Sub-module skin_bbox_acc: x/y counters, min/max tracking, saturating count; clear/enable inputs.
- The top level holds the FSM, the threshold registers and the edge detectors.

Test Plan:
- Reset then read thresholds -> thr outputs = 77/130/137/162; res_valid stays 0 with no vsync.
- 16x8 frame, det_en=1, mask=1 at (3,2),(10,5) -> after closing vs_rise + 2 clk: res_valid pulse; skin_cnt=2, box x 3..10, y 2..5, det_found=0 (MIN_PIX=256).
- Full 32x16 frame with all mask=1 -> skin_cnt=512, box 0..31 / 0..15, det_found=1.
- Write cb_lo=90 mid-frame -> thr_cb_lo remains 77 until the next vs_rise, then 90 on that cycle. Same-cycle write at vs_rise -> commit deferred one frame.
- det_en dropped mid-frame -> the current frame still reports; the next frame reports nothing; busy=0 after LATCH.
- Assert rst mid-frame, then run a 2-pixel frame -> no stale result; the first res_valid reflects only the post-reset frame.

Source files
------------

// File: rtl/skin_det_pkg.sv
// Shared definitions for the skin-mask frame controller and the YCbCr datapath.
package skin_det_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2
  } frame_state_e;

  // Threshold register addresses on the cfg bus.
  localparam logic [1:0] ADDR_CB_LO = 2'd0;
  localparam logic [1:0] ADDR_CB_HI = 2'd1;
  localparam logic [1:0] ADDR_CR_LO = 2'd2;
  localparam logic [1:0] ADDR_CR_HI = 2'd3;

  // Default skin window; the datapath uses the same values out of reset.
  localparam logic [7:0] CB_LO_DEF = 8'd77;
  localparam logic [7:0] CB_HI_DEF = 8'd130;
  localparam logic [7:0] CR_LO_DEF = 8'd137;
  localparam logic [7:0] CR_HI_DEF = 8'd162;

endpackage

// File: rtl/skin_det_frame_ctrl_acc.sv
// Per-frame skin accumulator: pixel coordinates, bounding box and saturating count.
module skin_bbox_acc
  import skin_det_pkg::*;
#(
  parameter int H_W   = 11,
  parameter int V_W   = 11,
  parameter int CNT_W = 21
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             de_i,
  input  logic             mask_i,
  input  logic             hr_fall_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [H_W-1:0]   xmin_o,
  output logic [H_W-1:0]   xmax_o,
  output logic [V_W-1:0]   ymin_o,
  output logic [V_W-1:0]   ymax_o
);

  localparam logic [H_W-1:0]   X_MAX   = '1;
  localparam logic [V_W-1:0]   Y_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [H_W-1:0]   x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [V_W-1:0]   y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             line_de_q, line_de_d;

  // Next-state for coordinates and box tracking; clear wins over accumulation.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    line_de_d = line_de_q;
    cnt_d     = cnt_q;
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymin_d    = ymin_q;
    ymax_d    = ymax_q;
    if (clear_i) begin
      x_d       = '0;
      y_d       = '0;
      line_de_d = 1'b0;
      cnt_d     = '0;
      xmin_d    = X_MAX;
      xmax_d    = '0;
      ymin_d    = Y_MAX;
      ymax_d    = '0;
    end else if (enable_i) begin
      if (de_i && mask_i) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (x_q < xmin_q) xmin_d = x_q;
        if (x_q > xmax_q) xmax_d = x_q;
        if (y_q < ymin_q) ymin_d = y_q;
        if (y_q > ymax_q) ymax_d = y_q;
      end
      if (hr_fall_i) begin
        x_d       = '0;
        line_de_d = 1'b0;
        if ((line_de_q || de_i) && (y_q != Y_MAX)) y_d = y_q + V_W'(1);
      end else if (de_i) begin
        line_de_d = 1'b1;
        if (x_q != X_MAX) x_d = x_q + H_W'(1);
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q       <= '0;
      y_q       <= '0;
      line_de_q <= 1'b0;
      cnt_q     <= '0;
      xmin_q    <= X_MAX;
      xmax_q    <= '0;
      ymin_q    <= Y_MAX;
      ymax_q    <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      line_de_q <= line_de_d;
      cnt_q     <= cnt_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign xmin_o = xmin_q;
  assign xmax_o = xmax_q;
  assign ymin_o = ymin_q;
  assign ymax_o = ymax_q;

endmodule

// File: rtl/skin_det_frame_ctrl.sv
// Frame controller: threshold shadowing, frame FSM and per-frame result record.
module skin_det_frame_ctrl
  import skin_det_pkg::*;
#(
  parameter int         H_W        = 11,
  parameter int         V_W        = 11,
  parameter int         CNT_W      = 21,
  parameter int         MIN_PIX    = 256,
  parameter logic [7:0] CB_LO_INIT = CB_LO_DEF,
  parameter logic [7:0] CB_HI_INIT = CB_HI_DEF,
  parameter logic [7:0] CR_LO_INIT = CR_LO_DEF,
  parameter logic [7:0] CR_HI_INIT = CR_HI_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             det_en_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [7:0]       cfg_wdata_i,
  input  logic             in_vsync_i,
  input  logic             in_href_i,
  input  logic             in_de_i,
  input  logic             in_mask_i,
  output logic [7:0]       thr_cb_lo_o,
  output logic [7:0]       thr_cb_hi_o,
  output logic [7:0]       thr_cr_lo_o,
  output logic [7:0]       thr_cr_hi_o,
  output logic             res_valid_o,
  output logic             det_found_o,
  output logic [CNT_W-1:0] skin_cnt_o,
  output logic [H_W-1:0]   box_xmin_o,
  output logic [H_W-1:0]   box_xmax_o,
  output logic [V_W-1:0]   box_ymin_o,
  output logic [V_W-1:0]   box_ymax_o,
  output logic             busy_o
);

  localparam logic [3:0][7:0]  THR_INIT  = {CR_HI_INIT, CR_LO_INIT, CB_HI_INIT, CB_LO_INIT};
  localparam logic [CNT_W-1:0] MIN_PIX_C = CNT_W'(MIN_PIX);

  logic            vs_d_q, hr_d_q, vs_rise, hr_fall;
  logic [3:0][7:0] shadow_q, active_q;
  logic            pending_q, pending_d, commit;
  frame_state_e    state_q, state_d;

  logic [CNT_W-1:0] acc_cnt;
  logic [H_W-1:0]   acc_xmin, acc_xmax;
  logic [V_W-1:0]   acc_ymin, acc_ymax;

  logic             res_valid_q, det_found_q;
  logic [CNT_W-1:0] skin_cnt_q;
  logic [H_W-1:0]   xmin_q, xmax_q;
  logic [V_W-1:0]   ymin_q, ymax_q;

  // One-cycle history of vsync and href for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_d_q <= 1'b0;
      hr_d_q <= 1'b0;
    end else begin
      vs_d_q <= in_vsync_i;
      hr_d_q <= in_href_i;
    end
  end

  assign vs_rise = in_vsync_i & ~vs_d_q;
  assign hr_fall = ~in_href_i & hr_d_q;
  assign commit  = vs_rise & pending_q;

  // A write in the commit cycle lands in the shadow and stays pending for the next frame.
  always_comb begin
    pending_d = pending_q;
    if (commit) pending_d = 1'b0;
    if (cfg_we_i) pending_d = 1'b1;
  end

  // Shadow, active threshold and pending-flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= THR_INIT;
      active_q  <= THR_INIT;
      pending_q <= 1'b0;
    end else begin
      if (cfg_we_i) shadow_q[cfg_addr_i] <= cfg_wdata_i;
      if (commit) active_q <= shadow_q;
      pending_q <= pending_d;
    end
  end

  // Frame sequencing: IDLE until enabled at a frame start, LATCH for one cycle per closed frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_rise && det_en_i) state_d = ACTIVE;
      ACTIVE:  if (vs_rise) state_d = LATCH;
      LATCH:   state_d = det_en_i ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  skin_bbox_acc #(
    .H_W   (H_W),
    .V_W   (V_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != ACTIVE),
    .enable_i  (state_q == ACTIVE),
    .de_i      (in_de_i),
    .mask_i    (in_mask_i),
    .hr_fall_i (hr_fall),
    .cnt_o     (acc_cnt),
    .xmin_o    (acc_xmin),
    .xmax_o    (acc_xmax),
    .ymin_o    (acc_ymin),
    .ymax_o    (acc_ymax)
  );

  // Result record is loaded only in LATCH; an empty frame reports a zero box.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_q <= 1'b0;
      det_found_q <= 1'b0;
      skin_cnt_q  <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
    end else begin
      res_valid_q <= (state_q == LATCH);
      if (state_q == LATCH) begin
        skin_cnt_q  <= acc_cnt;
        det_found_q <= (acc_cnt >= MIN_PIX_C);
        if (acc_cnt == '0) begin
          xmin_q <= '0;
          xmax_q <= '0;
          ymin_q <= '0;
          ymax_q <= '0;
        end else begin
          xmin_q <= acc_xmin;
          xmax_q <= acc_xmax;
          ymin_q <= acc_ymin;
          ymax_q <= acc_ymax;
        end
      end
    end
  end

  assign thr_cb_lo_o = active_q[ADDR_CB_LO];
  assign thr_cb_hi_o = active_q[ADDR_CB_HI];
  assign thr_cr_lo_o = active_q[ADDR_CR_LO];
  assign thr_cr_hi_o = active_q[ADDR_CR_HI];
  assign res_valid_o = res_valid_q;
  assign det_found_o = det_found_q;
  assign skin_cnt_o  = skin_cnt_q;
  assign box_xmin_o  = xmin_q;
  assign box_xmax_o  = xmax_q;
  assign box_ymin_o  = ymin_q;
  assign box_ymax_o  = ymax_q;
  assign busy_o      = (state_q == ACTIVE);

endmodule

// File: tb/tb_skin_det_frame_ctrl.sv
// Self-checking bench for skin_det_frame_ctrl against a frame-level reference model.
module tb_skin_det_frame_ctrl;

  localparam int MIN_PIX = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, det_en, cfg_we, in_vsync, in_href, in_de, in_mask;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  thr_cb_lo, thr_cb_hi, thr_cr_lo, thr_cr_hi;
  logic        res_valid, det_found, busy;
  logic [20:0] skin_cnt;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;

  skin_det_frame_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .det_en_i    (det_en),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .in_vsync_i  (in_vsync),
    .in_href_i   (in_href),
    .in_de_i     (in_de),
    .in_mask_i   (in_mask),
    .thr_cb_lo_o (thr_cb_lo),
    .thr_cb_hi_o (thr_cb_hi),
    .thr_cr_lo_o (thr_cr_lo),
    .thr_cr_hi_o (thr_cr_hi),
    .res_valid_o (res_valid),
    .det_found_o (det_found),
    .skin_cnt_o  (skin_cnt),
    .box_xmin_o  (box_xmin),
    .box_xmax_o  (box_xmax),
    .box_ymin_o  (box_ymin),
    .box_ymax_o  (box_ymax),
    .busy_o      (busy)
  );

  int nChecks = 0;
  int nFails  = 0;
  int pulseCnt = 0;
  int pulseExp = 0;

  // Reference model state
  logic [7:0] shadowExp [4];
  logic [7:0] activeExp [4];
  bit         pendExp;
  bit         tracked;
  int         expCnt, exMinX, exMaxX, exMinY, exMaxY, curRow;
  int         lastCnt, lastDet, lastXmin, lastXmax, lastYmin, lastYmax;
  bit         maskMap [32][32];
  int         wrRow = -1;
  logic [1:0] wrAddr;
  logic [7:0] wrData;

  // Count every result pulse seen, away from the active edge
  always @(negedge clk) if (res_valid === 1'b1) pulseCnt++;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    expCnt = 0; exMinX = 1 << 30; exMaxX = -1; exMinY = 1 << 30; exMaxY = -1; curRow = 0;
  endtask

  task automatic initModel();
    shadowExp[0] = 8'd77; shadowExp[1] = 8'd130; shadowExp[2] = 8'd137; shadowExp[3] = 8'd162;
    for (int i = 0; i < 4; i++) activeExp[i] = shadowExp[i];
    pendExp = 0; tracked = 0;
    lastCnt = 0; lastDet = 0; lastXmin = 0; lastXmax = 0; lastYmin = 0; lastYmax = 0;
    clearModel();
  endtask

  task automatic clearMask();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) maskMap[r][c] = 1'b0;
  endtask

  task automatic checkThr(input string tag);
    checkOutput(tag, {thr_cb_lo, thr_cb_hi, thr_cr_lo, thr_cr_hi},
                {activeExp[0], activeExp[1], activeExp[2], activeExp[3]});
  endtask

  task automatic modelPixel(input int c, input int r);
    expCnt++;
    if (c < exMinX) exMinX = c;
    if (c > exMaxX) exMaxX = c;
    if (r < exMinY) exMinY = r;
    if (r > exMaxY) exMaxY = r;
  endtask

  task automatic cfgWrite(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    in_href = 1'b0; in_de = 1'b0;
    step();
    cfg_we = 1'b0;
    shadowExp[a] = d; pendExp = 1;
    checkThr("thr_hold");
  endtask

  // Drive h pixel lines of width w; optional de gaps and de-less lines
  task automatic applyStimulus(input int w, input int h, input bit gaps);
    for (int r = 0; r < h; r++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        in_href = 1'b1; in_de = 1'b0; in_mask = 1'b1;
        repeat (3) step();
        in_href = 1'b0; in_mask = 1'b0;
        repeat (2) step();
      end
      for (int c = 0; c < w; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          in_href = 1'b1; in_de = 1'b0; in_mask = 1'b1;
          step();
        end
        in_href = 1'b1; in_de = 1'b1; in_mask = maskMap[r][c];
        if (maskMap[r][c]) modelPixel(c, curRow);
        step();
      end
      curRow++;
      in_href = 1'b0; in_de = 1'b0; in_mask = 1'b0;
      repeat (2) step();
      if (r == wrRow) begin
        cfgWrite(wrAddr, wrData);
        wrRow = -1;
      end
    end
  endtask

  // Close the current frame / open the next one, checking commit and result timing
  task automatic frameBoundary(input bit doWr, input logic [1:0] a, input logic [7:0] d);
    bit wasTracked;
    int bx0, bx1, by0, by1;
    wasTracked = tracked;
    in_vsync = 1'b1; in_href = 1'b0; in_de = 1'b0; in_mask = 1'b0;
    if (doWr) begin
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    end
    if (pendExp) begin
      for (int i = 0; i < 4; i++) activeExp[i] = shadowExp[i];
      pendExp = 0;
    end
    if (doWr) begin
      shadowExp[a] = d; pendExp = 1;
    end
    step();
    cfg_we = 1'b0;
    checkThr("thr_commit");
    checkOutput("busy_e0", busy, wasTracked ? 1'b0 : det_en);
    checkOutput("rv_e0", res_valid, 0);
    step();
    if (wasTracked) begin
      if (expCnt == 0) begin
        bx0 = 0; bx1 = 0; by0 = 0; by1 = 0;
      end else begin
        bx0 = exMinX; bx1 = exMaxX; by0 = exMinY; by1 = exMaxY;
      end
      pulseExp++;
      checkOutput("rv_e1", res_valid, 1);
      checkOutput("skin_cnt", skin_cnt, expCnt);
      checkOutput("det_found", det_found, (expCnt >= MIN_PIX) ? 1 : 0);
      checkOutput("xmin", box_xmin, bx0);
      checkOutput("xmax", box_xmax, bx1);
      checkOutput("ymin", box_ymin, by0);
      checkOutput("ymax", box_ymax, by1);
      lastCnt = expCnt; lastDet = (expCnt >= MIN_PIX) ? 1 : 0;
      lastXmin = bx0; lastXmax = bx1; lastYmin = by0; lastYmax = by1;
    end else begin
      checkOutput("rv_none", res_valid, 0);
      checkOutput("cnt_hold", skin_cnt, lastCnt);
      checkOutput("xmax_hold", box_xmax, lastXmax);
    end
    checkOutput("busy_e1", busy, det_en);
    in_vsync = 1'b0;
    step();
    checkOutput("rv_e2", res_valid, 0);
    tracked = det_en;
    clearModel();
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_vsync = 1'b0; in_href = 1'b0; in_de = 1'b0; in_mask = 1'b0; cfg_we = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    initModel();
    checkThr("thr_reset");
    checkOutput("rv_reset", res_valid, 0);
    checkOutput("cnt_reset", skin_cnt, 0);
    checkOutput("det_reset", det_found, 0);
    checkOutput("box_reset", {box_xmin, box_xmax, box_ymin, box_ymax}, 0);
    checkOutput("busy_reset", busy, 0);
  endtask

  initial begin
    rst = 1'b1; det_en = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
    in_vsync = 1'b0; in_href = 1'b0; in_de = 1'b0; in_mask = 1'b0;
    clearMask();
    doReset();
    repeat (6) step();
    checkOutput("rv_idle", pulseCnt, 0);

    // Two-pixel frame on a 16x8 raster
    det_en = 1'b1;
    frameBoundary(0, 2'd0, 8'd0);
    clearMask();
    maskMap[2][3] = 1'b1; maskMap[5][10] = 1'b1;
    applyStimulus(16, 8, 0);
    frameBoundary(0, 2'd0, 8'd0);

    // Full 32x16 skin frame with a mid-frame cb_lo write
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) maskMap[r][c] = 1'b1;
    wrRow = 4; wrAddr = 2'd0; wrData = 8'd90;
    applyStimulus(32, 16, 0);
    checkOutput("cb_lo_old", thr_cb_lo, 77);
    frameBoundary(0, 2'd0, 8'd0);
    checkOutput("cb_lo_new", thr_cb_lo, 90);

    // Empty frame, closed by a boundary carrying a same-cycle cb_hi write
    clearMask();
    applyStimulus(6, 3, 1);
    frameBoundary(1, 2'd1, 8'd140);
    checkOutput("cb_hi_defer", thr_cb_hi, 130);
    applyStimulus(4, 2, 0);
    frameBoundary(0, 2'd0, 8'd0);
    checkOutput("cb_hi_late", thr_cb_hi, 140);

    // Enable dropped mid-frame: this frame reports, the next does not
    maskMap[0][1] = 1'b1; maskMap[1][5] = 1'b1;
    applyStimulus(8, 2, 0);
    det_en = 1'b0;
    applyStimulus(8, 2, 0);
    frameBoundary(0, 2'd0, 8'd0);
    checkOutput("busy_off", busy, 0);
    applyStimulus(8, 2, 0);
    frameBoundary(0, 2'd0, 8'd0);
    det_en = 1'b1;
    frameBoundary(0, 2'd0, 8'd0);

    // Randomized frames with random writes and enable
    for (int it = 0; it < 8; it++) begin
      int w, h, dens;
      w = $urandom_range(1, 24);
      h = $urandom_range(1, 12);
      dens = $urandom_range(1, 3);
      clearMask();
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          maskMap[r][c] = (it == 2) ? 1'b0 : ($urandom_range(0, 3) < dens);
      if ($urandom_range(0, 1) == 1) begin
        wrRow = $urandom_range(0, h - 1);
        wrAddr = 2'($urandom);
        wrData = 8'($urandom);
      end
      applyStimulus(w, h, 1);
      det_en = ((it % 4) != 3);
      frameBoundary($urandom_range(0, 2) == 0, 2'($urandom), 8'($urandom));
    end

    // Reset in mid-frame, then a two-pixel frame
    det_en = 1'b1;
    frameBoundary(0, 2'd0, 8'd0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) maskMap[r][c] = 1'b1;
    applyStimulus(8, 3, 0);
    doReset();
    frameBoundary(0, 2'd0, 8'd0);
    clearMask();
    maskMap[0][0] = 1'b1; maskMap[0][1] = 1'b1;
    applyStimulus(2, 1, 0);
    frameBoundary(0, 2'd0, 8'd0);
    checkOutput("post_reset_cnt", skin_cnt, 2);

    repeat (3) step();
    checkOutput("pulse_total", pulseCnt, pulseExp);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
